eight_x_three_priority_encoder: RTL and testbench

- Inverse of the 3-to-8 select decoder: captures events on eight individual request lines (in0..in7) and presents one at a time as a 3-bit index with a valid/ack handshake.
- Sits in front of the decoder-driven select paths. It serves as the interrupt/request encoder so a consumer can service lines one by one.
- Rising edges are latched into a sticky pending register. Pending lines are encoded by priority and cleared on acknowledge.

---
 rtl/eight_x_three_priority_encoder_if.sv | 21 ++
 rtl/eight_x_three_priority_encoder.sv | 90 +++++++++
 tb/tb_eight_x_three_priority_encoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/eight_x_three_priority_encoder_if.sv
// Request/grant bundle for the eight-line priority encoder.
// master drives requests, enable and ack; slave returns code, valid, pending and overrun.
interface eight_x_three_priority_encoder_if;
    logic       enable;
    logic       in0, in1, in2, in3, in4, in5, in6, in7;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       overrun;

    modport master (
        output enable, in0, in1, in2, in3, in4, in5, in6, in7, ack,
        input  code, valid, pending, overrun
    );

    modport slave (
        input  enable, in0, in1, in2, in3, in4, in5, in6, in7, ack,
        output code, valid, pending, overrun
    );
endinterface

// File: rtl/eight_x_three_priority_encoder.sv
// Latches rising edges on eight request lines and grants them one at a time
// as a 3-bit code with a valid/ack handshake. Define ENCODER_ROUND_ROBIN_EN for rotating priority.
//
// state | meaning
// IDLE  | no grant outstanding, valid=0; waiting for enable and a pending line
// HOLD  | code is granted, valid=1; waiting for ack
module eight_x_three_priority_encoder (
    input logic clk,
    input logic reset,
    eight_x_three_priority_encoder_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t     state, state_n;
    logic [7:0] req, prev, edges;
    logic [7:0] pending_q, pending_n, clear_mask;
    logic [2:0] code_q, code_n, start, win, idx;
    logic       found, honoured, overrun_q, overrun_n;

    assign req   = {bus.in7, bus.in6, bus.in5, bus.in4, bus.in3, bus.in2, bus.in1, bus.in0};
    assign edges = bus.enable ? (req & ~prev) : 8'h00;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [2:0] ptr;

    always_ff @(posedge clk) begin
        if (reset)         ptr <= 3'b111;
        else if (honoured) ptr <= code_q;
    end

    assign start = ptr + 3'd1;
`else
    assign start = 3'd0;
`endif

    // Search begins at start and wraps 7->0; start is 0 in fixed-priority builds.
    always_comb begin
        win   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && pending_q[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= 8'h00;
            pending_q <= 8'h00;
            code_q    <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_n;
            prev      <= req;
            pending_q <= pending_n;
            code_q    <= code_n;
            overrun_q <= overrun_n;
        end
    end

    always_comb begin
        state_n = state;
        code_n  = code_q;
        case (state)
            IDLE: if (bus.enable && found) begin
                state_n = HOLD;
                code_n  = win;
            end
            HOLD: if (bus.ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A same-cycle edge re-sets a bit being cleared, and is not an overrun.
        pending_n = (pending_q & ~clear_mask) | edges;
        overrun_n = |(edges & pending_q & ~clear_mask);
    end

    always_comb begin
        honoured    = (state == HOLD) && bus.ack;
        clear_mask  = honoured ? (8'h01 << code_q) : 8'h00;
        bus.valid   = (state == HOLD);
        bus.code    = code_q;
        bus.pending = pending_q;
        bus.overrun = overrun_q;
    end
endmodule

// File: tb/tb_eight_x_three_priority_encoder.sv
// Directed bench for eight_x_three_priority_encoder; expected sequence in the priority
// test follows ENCODER_ROUND_ROBIN_EN.
module tb_eight_x_three_priority_encoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] req = 8'h00;
    int         total = 0;
    int         bad = 0;

    eight_x_three_priority_encoder_if bus ();

    assign bus.enable = enable;
    assign bus.ack    = ack;
    assign bus.in0    = req[0];
    assign bus.in1    = req[1];
    assign bus.in2    = req[2];
    assign bus.in3    = req[3];
    assign bus.in4    = req[4];
    assign bus.in5    = req[5];
    assign bus.in6    = req[6];
    assign bus.in7    = req[7];

    eight_x_three_priority_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        total++; if (bus.code !== 3'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", bus.code); end
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL reset_pending got=%h exp=00", bus.pending); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    endtask

    task automatic test_single();
        enable = 1'b1;
        req = 8'h08;
        step();
        total++; if (bus.pending !== 8'h08) begin bad++; $display("FAIL single_pending got=%h exp=08", bus.pending); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL single_valid_e0 got=%b exp=0", bus.valid); end
        step();
        total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL single_valid_e1 got=%b exp=1", bus.valid); end
        total++; if (bus.code !== 3'd3) begin bad++; $display("FAIL single_code got=%0d exp=3", bus.code); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL single_valid_ack got=%b exp=0", bus.valid); end
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL single_pending_ack got=%h exp=00", bus.pending); end
        req = 8'h00;
        step();
    endtask

    task automatic test_two_lines();
        req = 8'h22;
        step();
        total++; if (bus.pending !== 8'h22) begin bad++; $display("FAIL two_pending got=%h exp=22", bus.pending); end
        step();
        total++; if (bus.code !== 3'd1 || bus.valid !== 1'b1) begin bad++; $display("FAIL two_first got=%0d/%b exp=1/1", bus.code, bus.valid); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++; if (bus.pending !== 8'h20 || bus.valid !== 1'b0) begin bad++; $display("FAIL two_after_ack got=%h/%b exp=20/0", bus.pending, bus.valid); end
        step();
        total++; if (bus.code !== 3'd5 || bus.valid !== 1'b1) begin bad++; $display("FAIL two_second got=%0d/%b exp=5/1", bus.code, bus.valid); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++; if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin bad++; $display("FAIL two_drained got=%h/%b exp=00/0", bus.pending, bus.valid); end
        req = 8'h00;
        step();
    endtask

    task automatic test_hold_stable();
        req = 8'h10;
        step();
        step();
        total++; if (bus.code !== 3'd4 || bus.valid !== 1'b1) begin bad++; $display("FAIL hold_grant got=%0d/%b exp=4/1", bus.code, bus.valid); end
        req = 8'h11;
        step();
        total++; if (bus.code !== 3'd4 || bus.pending !== 8'h11) begin bad++; $display("FAIL hold_code got=%0d/%h exp=4/11", bus.code, bus.pending); end
        step();
        total++; if (bus.code !== 3'd4 || bus.valid !== 1'b1) begin bad++; $display("FAIL hold_code_later got=%0d/%b exp=4/1", bus.code, bus.valid); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++; if (bus.pending !== 8'h01 || bus.valid !== 1'b0) begin bad++; $display("FAIL hold_after_ack got=%h/%b exp=01/0", bus.pending, bus.valid); end
        step();
        total++; if (bus.code !== 3'd0 || bus.valid !== 1'b1) begin bad++; $display("FAIL hold_next got=%0d/%b exp=0/1", bus.code, bus.valid); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        req = 8'h00;
        step();
    endtask

    task automatic test_overrun();
        req = 8'h06;
        step();
        step();
        total++; if (bus.code !== 3'd1 || bus.valid !== 1'b1) begin bad++; $display("FAIL ovr_grant got=%0d/%b exp=1/1", bus.code, bus.valid); end
        req = 8'h02;
        step();
        req = 8'h06;
        step();
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b exp=1", bus.overrun); end
        total++; if (bus.pending !== 8'h06) begin bad++; $display("FAIL ovr_pending got=%h exp=06", bus.pending); end
        step();
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_one_cycle got=%b exp=0", bus.overrun); end
        ack = 1'b1;
        req = 8'h02;
        step();
        ack = 1'b0;
        total++; if (bus.pending !== 8'h04) begin bad++; $display("FAIL ovr_ack1 got=%h exp=04", bus.pending); end
        step();
        total++; if (bus.code !== 3'd2 || bus.valid !== 1'b1) begin bad++; $display("FAIL ovr_grant2 got=%0d/%b exp=2/1", bus.code, bus.valid); end
        ack = 1'b1;
        req = 8'h06;
        step();
        ack = 1'b0;
        total++; if (bus.pending !== 8'h04) begin bad++; $display("FAIL edge_wins got=%h exp=04", bus.pending); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL edge_wins_ovr got=%b exp=0", bus.overrun); end
        step();
        total++; if (bus.code !== 3'd2 || bus.valid !== 1'b1) begin bad++; $display("FAIL ovr_regrant got=%0d/%b exp=2/1", bus.code, bus.valid); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL ovr_drained got=%h exp=00", bus.pending); end
        req = 8'h00;
        step();
    endtask

    task automatic test_disable_and_reset();
        enable = 1'b0;
        req = 8'h40;
        step();
        step();
        total++; if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin bad++; $display("FAIL dis_capture got=%h/%b exp=00/0", bus.pending, bus.valid); end
        enable = 1'b1;
        step();
        step();
        total++; if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin bad++; $display("FAIL dis_no_late_edge got=%h/%b exp=00/0", bus.pending, bus.valid); end
        req = 8'h80;
        step();
        step();
        total++; if (bus.code !== 3'd7 || bus.valid !== 1'b1) begin bad++; $display("FAIL rst_pre_grant got=%0d/%b exp=7/1", bus.code, bus.valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (bus.valid !== 1'b0 || bus.code !== 3'd0 || bus.pending !== 8'h00) begin bad++; $display("FAIL rst_mid got=%b/%0d/%h exp=0/0/00", bus.valid, bus.code, bus.pending); end
        step();
        total++; if (bus.pending !== 8'h80) begin bad++; $display("FAIL rst_held_edge got=%h exp=80", bus.pending); end
        step();
        total++; if (bus.code !== 3'd7 || bus.valid !== 1'b1) begin bad++; $display("FAIL rst_regrant got=%0d/%b exp=7/1", bus.code, bus.valid); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        req = 8'h00;
        step();
    endtask

    task automatic test_ack_idle();
        ack = 1'b1;
        req = 8'h08;
        step();
        total++; if (bus.pending !== 8'h08 || bus.valid !== 1'b0) begin bad++; $display("FAIL idle_ack_pending got=%h/%b exp=08/0", bus.pending, bus.valid); end
        step();
        total++; if (bus.code !== 3'd3 || bus.valid !== 1'b1 || bus.pending !== 8'h08) begin bad++; $display("FAIL idle_ack_grant got=%0d/%b/%h exp=3/1/08", bus.code, bus.valid, bus.pending); end
        step();
        ack = 1'b0;
        total++; if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin bad++; $display("FAIL idle_ack_done got=%b/%h exp=0/00", bus.valid, bus.pending); end
        req = 8'h00;
        step();
    endtask

    task automatic test_priority_sequence();
        logic [2:0] exp_seq [4];
`ifdef ENCODER_ROUND_ROBIN_EN
        exp_seq = '{3'd0, 3'd1, 3'd0, 3'd1};
`else
        exp_seq = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
        req = 8'h03;
        step();
        for (int g = 0; g < 4; g++) begin
            step();
            total++; if (bus.code !== exp_seq[g] || bus.valid !== 1'b1) begin bad++; $display("FAIL seq_grant%0d got=%0d/%b exp=%0d/1", g, bus.code, bus.valid, exp_seq[g]); end
            req = 8'h00;
            step();
            req = 8'h03;
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
        reset = 1'b1;
        req = 8'h00;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_lines();
        test_hold_stable();
        test_overrun();
        test_disable_and_reset();
        test_ack_idle();
        test_priority_sequence();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
